// File: rtl/id_ex_register.sv
// ----------------------------------------------------------------------------
// id_ex_register
//
// Pipeline register between the decode (ID) and execute (EX) stages.
// On each rising clock edge it does one of four things, in priority order:
// reset, flush, stall or load.
//   - flush : loads a bubble, meaning every EX field is zero and EX_valid is 0.
//   - stall : holds the current EX contents.
//   - load  : copies the ID fields into EX. When ID_valid is 0, the control
//             word is forced to zero so that an invalid slot cannot write the
//             register file or memory.
// bubble_count counts the bubbles inserted since reset and saturates at
// 16'hFFFF. A bubble is a flush edge, or a load edge with ID_valid = 0.
//
// Ports
//   clk, reset        : rising-edge clock; synchronous active-high reset
//   stall, flush      : hazard-unit hold / squash requests
//   ID_valid          : decode slot holds a real instruction
//   ID_ALU_op[1:0]    : ALU op class (00 ld/st, 01 branch, 10 R-type)
//   ID_funct[5:0]     : instruction bits [5:0]
//   ID_ctrl[6:0]      : {RegWrite, MemRead, MemWrite, MemtoReg, RegDst,
//                        ALUSrc, Branch}
//   ID_pc_plus4, ID_rd1, ID_rd2, ID_imm [31:0] : datapath operands
//   ID_regs[14:0]     : {rs, rt, rd}
//   EX_*              : registered copies of the ID_* fields
//   EX_valid          : EX slot holds a real instruction
//   bubble_count[15:0]: saturating count of inserted bubbles
// ----------------------------------------------------------------------------
module id_ex_register (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        ID_valid,
    input  logic [1:0]  ID_ALU_op,
    input  logic [5:0]  ID_funct,
    input  logic [6:0]  ID_ctrl,
    input  logic [31:0] ID_pc_plus4,
    input  logic [31:0] ID_rd1,
    input  logic [31:0] ID_rd2,
    input  logic [31:0] ID_imm,
    input  logic [14:0] ID_regs,
    output logic        EX_valid,
    output logic [1:0]  EX_ALU_op,
    output logic [5:0]  EX_funct,
    output logic [6:0]  EX_ctrl,
    output logic [31:0] EX_pc_plus4,
    output logic [31:0] EX_rd1,
    output logic [31:0] EX_rd2,
    output logic [31:0] EX_imm,
    output logic [14:0] EX_regs,
    output logic [15:0] bubble_count
);

    logic        valid_q,  valid_d;
    logic [1:0]  alu_op_q, alu_op_d;
    logic [5:0]  funct_q,  funct_d;
    logic [6:0]  ctrl_q,   ctrl_d;
    logic [31:0] pc4_q,    pc4_d;
    logic [31:0] rd1_q,    rd1_d;
    logic [31:0] rd2_q,    rd2_d;
    logic [31:0] imm_q,    imm_d;
    logic [14:0] regs_q,   regs_d;
    logic [15:0] bcnt_q,   bcnt_d;
    logic        bubble;

    // Next-state selection. Reset is applied in the register process.
    always_comb begin
        valid_d  = valid_q;
        alu_op_d = alu_op_q;
        funct_d  = funct_q;
        ctrl_d   = ctrl_q;
        pc4_d    = pc4_q;
        rd1_d    = rd1_q;
        rd2_d    = rd2_q;
        imm_d    = imm_q;
        regs_d   = regs_q;
        bubble   = 1'b0;

        if (flush) begin
            // Bubble: ALU_op=00 with funct=0 decodes downstream as a harmless ADD.
            valid_d  = 1'b0;
            alu_op_d = '0;
            funct_d  = '0;
            ctrl_d   = '0;
            pc4_d    = '0;
            rd1_d    = '0;
            rd2_d    = '0;
            imm_d    = '0;
            regs_d   = '0;
            bubble   = 1'b1;
        end else if (!stall) begin
            valid_d  = ID_valid;
            alu_op_d = ID_ALU_op;
            funct_d  = ID_funct;
            // An invalid slot still carries its data, but it gets no control.
            ctrl_d   = ID_valid ? ID_ctrl : '0;
            pc4_d    = ID_pc_plus4;
            rd1_d    = ID_rd1;
            rd2_d    = ID_rd2;
            imm_d    = ID_imm;
            regs_d   = ID_regs;
            bubble   = !ID_valid;
        end
    end

    // Saturating bubble counter.
    always_comb begin
        bcnt_d = bcnt_q;
        if (bubble && (bcnt_q != '1)) begin
            bcnt_d = bcnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q  <= 1'b0;
            alu_op_q <= '0;
            funct_q  <= '0;
            ctrl_q   <= '0;
            pc4_q    <= '0;
            rd1_q    <= '0;
            rd2_q    <= '0;
            imm_q    <= '0;
            regs_q   <= '0;
            bcnt_q   <= '0;
        end else begin
            valid_q  <= valid_d;
            alu_op_q <= alu_op_d;
            funct_q  <= funct_d;
            ctrl_q   <= ctrl_d;
            pc4_q    <= pc4_d;
            rd1_q    <= rd1_d;
            rd2_q    <= rd2_d;
            imm_q    <= imm_d;
            regs_q   <= regs_d;
            bcnt_q   <= bcnt_d;
        end
    end

    assign EX_valid     = valid_q;
    assign EX_ALU_op    = alu_op_q;
    assign EX_funct     = funct_q;
    assign EX_ctrl      = ctrl_q;
    assign EX_pc_plus4  = pc4_q;
    assign EX_rd1       = rd1_q;
    assign EX_rd2       = rd2_q;
    assign EX_imm       = imm_q;
    assign EX_regs      = regs_q;
    assign bubble_count = bcnt_q;

endmodule
